hex_word_display: RTL and testbench
===================================

# hex_word_display

Downstream consumer of the AES core's 32-bit result port: accepts a 128-bit ciphertext block as four 32-bit words over a valid/ready handshake and buffers them. It then pages through the words on the eight DE2 seven-segment displays, holding each word for a programmable dwell time. After one full pass it returns to accepting the next block. It sits between the Nios AES system's readout and the board HEX pins, replacing direct per-digit wiring.

## Interface
- DWELL_CYCLES, 50_000_000, clock cycles each word stays on display (1 s at 50 MHz); legal range ≥ 2.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- word_in  in  32  ciphertext word; word 0 is the first word of the block.
- word_valid  in  1  word_in is valid this cycle.
- word_ready  out  1  block can accept a word this cycle.
- freeze  in  1  while high in SHOW, the current page and dwell count hold.
- page_idx  out  2  index of the word currently shown; 0 in FILL.
- block_shown  out  1  one-cycle pulse when a full pass completes.
- HEX0..HEX7  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 = word[3:0], HEX7 = word[31:28].

## Operation
- States: FILL, SHOW. Reset state is FILL.
- FILL:
  - word_ready = 1 (combinational from state).
  - On each edge with word_valid & word_ready, store word_in into buf[wr_ptr] and increment wr_ptr (2 bits).
  - The edge that accepts the 4th word (wr_ptr == 3) does all of the following: state ← SHOW, wr_ptr ← 0, page ← 0, cnt ← 0, disp_reg ← buf[0].
- SHOW:
  - word_ready = 0. word_valid is ignored and causes no buffer writes.
  - The cnt increment and page advance below apply only when freeze is low. When freeze is high, cnt, page and disp_reg hold.
  - cnt counts 0..DWELL_CYCLES−1; its width is clog2(DWELL_CYCLES).
  - When cnt == DWELL_CYCLES−1:
    - If page < 3: page ← page+1, disp_reg ← buf[page+1], cnt ← 0.
    - If page == 3: state ← FILL, page ← 0, cnt ← 0, block_shown ← 1 for one cycle. disp_reg is unchanged, so the last word stays visible while the next block fills.
- Display:
  - disp_reg is a separate 32-bit latch, so overwriting buf during FILL never alters the HEX outputs.
  - HEXn is the combinational decode of disp_reg[4n+3:4n].
  - Segment codes for 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
  - A blank flag, set by reset and cleared on the first disp_reg load, forces all HEX outputs to 7F.
- Reset (asynchronous, any time, including mid-FILL or mid-SHOW):
  - state = FILL, wr_ptr = 0, page = 0, cnt = 0, block_shown = 0, blank = 1.
  - disp_reg = 0. buf contents are don't-care.
  - A partially received block is discarded.

## Timing
- Reset values of outputs: word_ready = 1, page_idx = 0, block_shown = 0, all HEX = 7F.
- Throughput in FILL: one word per cycle. A back-to-back block completes in 4 cycles.
- Latency: the HEX outputs show word 0 immediately after the edge that accepts word 3. word_ready drops on that same edge.
- Each page is shown exactly DWELL_CYCLES cycles, plus any cycles with freeze high.
- block_shown is asserted in the cycle after the final dwell edge, coincident with word_ready returning to 1. A word can be accepted in that same cycle.
- freeze asserted in FILL has no effect.
- freeze and the terminal count in the same cycle: freeze wins, so no advance.

## Test plan
- Reset: assert resetn = 0 mid-SHOW → within the same cycle, HEX0..7 = 7F, word_ready = 1, page_idx = 0. Release, then send 4 words → normal display starts at page 0.
- Basic pass (DWELL_CYCLES = 4): send 0x0123_4567, 0x89AB_CDEF, 0xDEAD_BEEF, 0xFFFF_0000 back-to-back.
  - Expected: HEX7..HEX0 = 40,79,24,30,19,12,02,78 for 4 cycles, then pages 1, 2, 3 for 4 cycles each.
  - block_shown then pulses and word_ready = 1.
  - HEX keeps showing 0xFFFF_0000.
- Gapped handshake: send word_valid with idle gaps (valid pattern 1,0,0,1,1,0,1) → exactly 4 words captured, in order; SHOW entered on the 4th accept.
- Backpressure: hold word_valid = 1 with word 0xAAAA_AAAA during SHOW → no buffer change and no HEX change. The first post-pass accept occurs in the block_shown cycle.
- Freeze: raise freeze for 10 cycles at cnt = 2 on page 1 → page 1 is visible for 14 cycles total. Freeze coinciding with cnt = 3 → no advance.
- Refill during display hold: after a pass, send a new block 0x1111_1111 ×4 → HEX shows the old word 3 until the 4th accept edge, then shows 79 on all digits.

Source files
------------

// File: rtl/hex_word_display.sv
// hex_word_display
//   Receives a 128-bit ciphertext block as four 32-bit words over a valid/ready
//   handshake. It then pages through the buffered words on the eight DE2
//   seven-segment displays, holding each word for DWELL_CYCLES clocks. After
//   one full pass it returns to accepting the next block.
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   word_in      ciphertext word; word 0 is the first word of the block
//   word_valid   word_in is valid this cycle
//   word_ready   a word can be accepted this cycle (high only while filling)
//   freeze       while high during display, the page and dwell count hold
//   page_idx     index of the word currently shown; 0 while filling
//   block_shown  one-cycle pulse when a full display pass completes
//   HEX0..HEX7   active-low segments {g,f,e,d,c,b,a}; HEX0 = word[3:0]
module hex_word_display #(
   parameter int unsigned DWELL_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic        freeze,
   output logic [1:0]  page_idx,
   output logic        block_shown,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic [6:0]  HEX6,
   output logic [6:0]  HEX7
);

   localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

   typedef enum logic {StFill, StShow} state_t;

   state_t           state;
   logic [1:0]       wr_ptr;
   logic [1:0]       page;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      disp_reg;
   logic             blank;
   logic [31:0]      word_buf [4];

   logic accept;

   assign word_ready = (state == StFill);
   assign accept     = word_valid & word_ready;
   assign page_idx   = page;

   // Block buffer has no reset: its contents only matter once all four
   // words of a block have been written.
   always_ff @(posedge clk) begin
      if (accept) begin
         word_buf[wr_ptr] <= word_in;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= StFill;
         wr_ptr      <= 2'd0;
         page        <= 2'd0;
         cnt         <= '0;
         block_shown <= 1'b0;
         blank       <= 1'b1;
         disp_reg    <= 32'd0;
      end else begin
         block_shown <= 1'b0;
         unique case (state)
            StFill: begin
               if (word_valid) begin
                  wr_ptr <= wr_ptr + 2'd1;
                  if (wr_ptr == 2'd3) begin
                     // Word 0 was written on an earlier edge, so it can be
                     // latched for display on the edge that takes word 3.
                     state    <= StShow;
                     wr_ptr   <= 2'd0;
                     page     <= 2'd0;
                     cnt      <= '0;
                     disp_reg <= word_buf[0];
                     blank    <= 1'b0;
                  end
               end
            end
            StShow: begin
               // freeze also wins over the terminal count
               if (!freeze) begin
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     if (page == 2'd3) begin
                        // disp_reg keeps the last word visible during refill
                        state       <= StFill;
                        page        <= 2'd0;
                        block_shown <= 1'b1;
                     end else begin
                        page     <= page + 2'd1;
                        disp_reg <= word_buf[page + 2'd1];
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= StFill;
         endcase
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign HEX0 = blank ? 7'h7F : seg7(disp_reg[3:0]);
   assign HEX1 = blank ? 7'h7F : seg7(disp_reg[7:4]);
   assign HEX2 = blank ? 7'h7F : seg7(disp_reg[11:8]);
   assign HEX3 = blank ? 7'h7F : seg7(disp_reg[15:12]);
   assign HEX4 = blank ? 7'h7F : seg7(disp_reg[19:16]);
   assign HEX5 = blank ? 7'h7F : seg7(disp_reg[23:20]);
   assign HEX6 = blank ? 7'h7F : seg7(disp_reg[27:24]);
   assign HEX7 = blank ? 7'h7F : seg7(disp_reg[31:28]);

endmodule

// File: tb/tb_hex_word_display.sv
module tb_hex_word_display;

   localparam int D = 4;

   logic        clk;
   logic        resetn;
   logic [31:0] word_in;
   logic        word_valid;
   logic        word_ready;
   logic        freeze;
   logic [1:0]  page_idx;
   logic        block_shown;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
   logic [55:0] hexcat;

   assign hexcat = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

   hex_word_display #(.DWELL_CYCLES(D)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .word_in     (word_in),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .freeze      (freeze),
      .page_idx    (page_idx),
      .block_shown (block_shown),
      .HEX0        (HEX0),
      .HEX1        (HEX1),
      .HEX2        (HEX2),
      .HEX3        (HEX3),
      .HEX4        (HEX4),
      .HEX5        (HEX5),
      .HEX6        (HEX6),
      .HEX7        (HEX7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: a block is collected in a queue; display position is
   // derived from the number of unfrozen cycles spent displaying.
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [31:0] m_q [$];
   logic [31:0] m_blk [4];
   bit          m_show;
   int          m_active;
   logic [31:0] m_disp;
   bit          m_blank;
   bit          m_pulse;

   function automatic logic [55:0] exp_hex();
      logic [55:0] h;
      for (int i = 0; i < 8; i++) begin
         h[7*i +: 7] = m_blank ? 7'h7F : seg_tab[m_disp[4*i +: 4]];
      end
      return h;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_show   = 0;
      m_active = 0;
      m_disp   = 32'd0;
      m_blank  = 1;
      m_pulse  = 0;
   endtask

   task automatic model_step(input logic v, input logic [31:0] w, input logic f);
      m_pulse = 0;
      if (!m_show) begin
         if (v) begin
            m_q.push_back(w);
            if (m_q.size() == 4) begin
               for (int i = 0; i < 4; i++) m_blk[i] = m_q[i];
               m_q.delete();
               m_show   = 1;
               m_active = 0;
               m_disp   = m_blk[0];
               m_blank  = 0;
            end
         end
      end else if (!f) begin
         m_active++;
         if (m_active == 4 * D) begin
            m_show   = 0;
            m_active = 0;
            m_pulse  = 1;
         end else begin
            m_disp = m_blk[m_active / D];
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/ready"}, 64'(word_ready), 64'(!m_show));
      check({tag, "/page"}, 64'(page_idx), 64'(m_show ? m_active / D : 0));
      check({tag, "/shown"}, 64'(block_shown), 64'(m_pulse));
      check({tag, "/hex"}, 64'(hexcat), 64'(exp_hex()));
   endtask

   // Called just after an active edge (+1); inputs change well away from edges.
   task automatic step(input logic v, input logic [31:0] w, input logic f, input string tag);
      word_valid = v;
      word_in    = w;
      freeze     = f;
      @(posedge clk);
      model_step(v, w, f);
      #1;
      check_all(tag);
   endtask

   initial begin
      int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      int pat2 [5] = '{1, 1, 0, 1, 1};
      int fz1, fz2, p1_cycles;
      bit seen;
      logic f;

      resetn     = 1'b1;
      word_valid = 1'b0;
      word_in    = 32'd0;
      freeze     = 1'b0;
      model_reset();
      #1 resetn = 1'b0;
      #1;
      check_all("reset");
      check("reset_blank", 64'(hexcat), 64'({8{7'h7F}}));
      @(posedge clk);
      #1 resetn = 1'b1;

      // Basic pass, back-to-back words
      step(1, 32'h0123_4567, 0, "basic_w0");
      step(1, 32'h89AB_CDEF, 0, "basic_w1");
      step(1, 32'hDEAD_BEEF, 0, "basic_w2");
      step(1, 32'hFFFF_0000, 0, "basic_w3");
      check("basic_first_page", 64'(hexcat),
            64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}));
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         step(0, $urandom, 0, "basic_show");
         seen = m_pulse;
      end
      check("basic_done", 64'(seen), 64'(1));
      check("basic_last_word", 64'(hexcat),
            64'({7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40}));
      repeat (3) step(0, 32'd0, 0, "basic_hold");

      // Gapped handshake with random words; freeze in FILL does nothing
      for (int i = 0; i < 7; i++) begin
         step(1'(pat[i]), $urandom, 1'($urandom_range(0, 1)), "gap");
      end
      check("gap_show_entered", 64'(word_ready), 64'(0));

      // Backpressure plus freeze: 10 cycles at cnt 2 of page 1, 2 at cnt 3 of page 2
      fz1 = 0;
      fz2 = 0;
      p1_cycles = 0;
      seen = 0;
      for (int c = 0; c < 80 && !seen; c++) begin
         f = 0;
         if (m_show && m_active == D + 2 && fz1 < 10) begin
            f = 1;
            fz1++;
         end
         if (m_show && m_active == 2 * D + 3 && fz2 < 2) begin
            f = 1;
            fz2++;
         end
         step(1, 32'hAAAA_AAAA, f, "bp");
         if (page_idx == 2'd1) p1_cycles++;
         seen = m_pulse;
      end
      check("bp_done", 64'(seen), 64'(1));
      check("freeze_page1_len", 64'(p1_cycles), 64'(D + 10));
      // Accept in the block_shown cycle, then three more
      step(1, 32'hAAAA_AAAA, 0, "bp_accept0");
      check("bp_first_accept", 64'(m_q.size()), 64'(1));
      repeat (3) step(1, 32'hAAAA_AAAA, 0, "bp_accept");
      check("bp_show_a", 64'(hexcat), 64'({8{7'h08}}));
      repeat (5) step(0, 32'd0, 0, "show_a");

      // Asynchronous reset mid-display
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid");
      check("rst_mid_blank", 64'(hexcat), 64'({8{7'h7F}}));
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // Fresh block after reset, full pass, then refill with 0x1111_1111
      repeat (4) step(1, $urandom, 0, "post_rst");
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         step(0, $urandom, 1'($urandom_range(0, 3) == 0), "post_rst_show");
         seen = m_pulse;
      end
      check("post_rst_done", 64'(seen), 64'(1));
      for (int i = 0; i < 5; i++) begin
         step(1'(pat2[i]), 32'h1111_1111, 0, "refill");
      end
      check("refill_ones", 64'(hexcat), 64'({8{7'h79}}));

      // Random traffic
      for (int c = 0; c < 300; c++) begin
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
